// File: rtl/dom_mask_source.sv
// Fresh-randomness source for the DOM-dep multiplier Z inputs: a Galois LFSR
// emits Z_W-bit mask words into a small show-ahead FIFO popped by valid/ready.
module dom_mask_source #(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1,
    parameter int                Z_W          = 2,
    parameter int                DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed,
    input  logic                     z_ready,
    output logic [Z_W-1:0]           z,
    output logic                     z_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     lockup
);

    // state | meaning
    // IDLE  | generation stopped, FIFO kept, pops still served
    // RUN   | one word pushed per cycle while FIFO has room
    typedef enum logic {IDLE, RUN} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t            state, state_d;
    logic [LFSR_W-1:0] lfsr, lfsr_nx;
    logic [Z_W-1:0]    word;
    logic [Z_W-1:0]    mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, push, pop;

    // Z_W LFSR steps per word; bit i of the word is the output of step i
    always_comb begin
        lfsr_nx = lfsr;
        word    = '0;
        for (int i = 0; i < Z_W; i++) begin
            word[i] = lfsr_nx[0];
            lfsr_nx = lfsr_nx[0] ? ((lfsr_nx >> 1) ^ TAPS) : (lfsr_nx >> 1);
        end
    end

    always_comb begin
        state_d = state;
        if (!seed_load) begin
            case (state)
                IDLE:    if (en)  state_d = RUN;
                RUN:     if (!en) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign full    = (level == LW'(DEPTH));
    assign z_valid = (level != '0) & ~seed_load;
    assign pop     = z_valid & z_ready;
    assign push    = (state == RUN) & en & (~full | pop) & ~seed_load;
    assign z       = z_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= DEFAULT_SEED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            lockup <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (seed_load) begin
            // a zero seed would lock the LFSR, so substitute the default
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            lockup <= (seed == '0);
            lfsr   <= (seed == '0) ? DEFAULT_SEED : seed;
        end else begin
            state <= state_d;
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
                lfsr        <= lfsr_nx;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
